ram_threshold_master: RTL and testbench
=======================================

RAM_THRESHOLD_MASTER -- requirements
Module: ram_threshold_master

Interface
REQ-001 SHALL have parameter DATA_W, default 16, RAM word and pixel width.
REQ-002 SHALL have parameter ADDR_W, default 10, RAM address width; the frame is 2**ADDR_W words (1024).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to process the whole frame.
REQ-006 SHALL have port thr  input  DATA_W  threshold, sampled only when start is accepted.
REQ-007 SHALL have port mod_en  output  1  RAM module select.
REQ-008 SHALL have port wr_en  output  1  RAM write enable.
REQ-009 SHALL have port rd_en  output  1  RAM read enable.
REQ-010 SHALL have port addr_in  output  ADDR_W  RAM address.
REQ-011 SHALL have port data_in  output  DATA_W  RAM write data.
REQ-012 SHALL have port data_o  input  DATA_W  RAM read data, valid one cycle after the rd_en cycle.
REQ-013 SHALL have port busy  output  1  high while a frame is being processed.
REQ-014 SHALL have port done  output  1  one-cycle pulse when the frame is complete.
REQ-015 SHALL have port fg_count  output  ADDR_W+1  number of foreground pixels in the last frame.

Function
REQ-016 SHALL implement the states IDLE, READ, WAIT, WRITE and DONE; all outputs SHALL be registered.
REQ-017 IDLE: start=1 SHALL latch thr, clear the address to 0, clear fg_count, and go to READ; otherwise it SHALL stay in IDLE.
REQ-018 READ SHALL drive mod_en=1, rd_en=1, wr_en=0 and addr_in=current address, then go to WAIT.
REQ-019 WAIT SHALL drive mod_en=0, rd_en=0 and wr_en=0.
REQ-019a In WAIT, data_in SHALL be set to all-ones if data_o >= latched thr (unsigned), else all-zeros, and the state SHALL go to WRITE.
REQ-020 WRITE SHALL drive mod_en=1, wr_en=1, rd_en=0 and addr_in=current address, and SHALL increment fg_count if data_in is all-ones.
REQ-021 From WRITE, the state SHALL go to DONE if the address is 2**ADDR_W-1; otherwise the address SHALL increment and the state SHALL go to READ.
REQ-022 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE; fg_count SHALL hold until the next accepted start.
REQ-023 busy SHALL be 1 in READ, WAIT and WRITE, and 0 in IDLE and DONE.
REQ-024 Timing: with start accepted at edge 0, the first READ SHALL be in cycle 1 and each pixel SHALL take 3 cycles.
REQ-024a The last WRITE SHALL be in cycle 3*2**ADDR_W (3072) and done SHALL be in cycle 3073.
REQ-025 wr_en and rd_en SHALL never be high in the same cycle.
REQ-026 start SHALL be ignored outside IDLE, including start on the cycle done is high.
REQ-027 Changes to thr after acceptance SHALL NOT affect the frame in progress.
REQ-028 The address counter SHALL NOT wrap past 2**ADDR_W-1 within a frame, and fg_count SHALL reach 2**ADDR_W without overflow.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE.
REQ-029a On reset, mod_en, wr_en, rd_en, busy and done SHALL be 0, addr_in, data_in and fg_count SHALL be 0, and latched thr SHALL be 0.
REQ-030 Reset mid-frame SHALL abandon the frame: words already written stay thresholded, the rest stay unchanged, and the next start SHALL restart at address 0.

Configuration
REQ-031 Macro THRESH_FG_COUNT_EN: when defined, fg_count SHALL operate per REQ-017/020/022.
REQ-032 When THRESH_FG_COUNT_EN is undefined, the fg_count port SHALL remain and be tied to 0, and no counter logic SHALL be present; all other behaviour SHALL be unchanged.

Verification
REQ-033 Preload word[a]=a, thr=512, start -> words 0..511 = 0x0000, words 512..1023 = 0xFFFF, fg_count=512, done in cycle 3073.
REQ-034 Preload word[a]=a, thr=0 -> all words = 0xFFFF, fg_count=1024 (11 bits, no overflow).
REQ-035 Preload all 0x0000, thr=0xFFFF -> all words = 0x0000, fg_count=0; then preload word 7 = 0xFFFF, rerun -> fg_count=1 and only word 7 = 0xFFFF.
REQ-036 Start with thr=512, then pulse start with thr=0 at cycle 50 -> second start ignored, result identical to REQ-033, and rd_en&&wr_en never observed.
REQ-037 rst_n=0 while addr_in=100 -> all outputs 0 asynchronously, words 100..1023 unchanged; a new start -> first READ at addr_in=0.
REQ-038 Build without THRESH_FG_COUNT_EN, rerun REQ-033 -> same RAM contents, fg_count stays 0.

Source files
------------

// File: rtl/ram_threshold_master.sv
// Streams a 2**ADDR_W-word frame through a RAM: read, compare with a latched threshold, write back 0/all-ones.
// Optional foreground pixel counter built only when THRESH_FG_COUNT_EN is defined; otherwise fg_count is tied to 0.
`timescale 1ns/1ps
module ram_threshold_master #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] thr,
   output logic              mod_en,
   output logic              wr_en,
   output logic              rd_en,
   output logic [ADDR_W-1:0] addr_in,
   output logic [DATA_W-1:0] data_in,
   input  logic [DATA_W-1:0] data_o,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   fg_count
);

   // state | meaning
   // IDLE  | waiting for start; thr latched on acceptance
   // READ  | RAM read of current address
   // WAIT  | read data arrives; thresholded word registered into data_in
   // WRITE | thresholded word written back to current address
   // DONE  | one-cycle completion pulse
   typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

   state_t            state;
   logic [DATA_W-1:0] thr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         thr_q   <= '0;
         mod_en  <= 1'b0;
         wr_en   <= 1'b0;
         rd_en   <= 1'b0;
         addr_in <= '0;
         data_in <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  thr_q   <= thr;
                  addr_in <= '0;
                  mod_en  <= 1'b1;
                  rd_en   <= 1'b1;
                  wr_en   <= 1'b0;
                  busy    <= 1'b1;
                  state   <= READ;
               end
            end
            READ: begin
               mod_en <= 1'b0;
               rd_en  <= 1'b0;
               wr_en  <= 1'b0;
               state  <= WAIT;
            end
            WAIT: begin
               data_in <= (data_o >= thr_q) ? '1 : '0;
               mod_en  <= 1'b1;
               wr_en   <= 1'b1;
               rd_en   <= 1'b0;
               state   <= WRITE;
            end
            WRITE: begin
               wr_en <= 1'b0;
               if (addr_in == ADDR_LAST) begin
                  mod_en <= 1'b0;
                  rd_en  <= 1'b0;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= DONE;
               end else begin
                  addr_in <= addr_in + ADDR_ONE;
                  mod_en  <= 1'b1;
                  rd_en   <= 1'b1;
                  state   <= READ;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               mod_en <= 1'b0;
               wr_en  <= 1'b0;
               rd_en  <= 1'b0;
               busy   <= 1'b0;
               done   <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

`ifdef THRESH_FG_COUNT_EN
   localparam logic [ADDR_W:0] FG_ONE = (ADDR_W+1)'(1);

   logic [ADDR_W:0] fg_q;

   // One extra bit so a fully-foreground frame (2**ADDR_W) is representable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fg_q <= '0;
      end else if (state == IDLE && start) begin
         fg_q <= '0;
      end else if (state == WRITE && (&data_in)) begin
         fg_q <= fg_q + FG_ONE;
      end
   end

   assign fg_count = fg_q;
`else
   assign fg_count = '0;
`endif

endmodule

// File: tb/tb_ram_threshold_master.sv
// Self-checking bench for ram_threshold_master: behavioural RAM, frame-level model and per-cycle compare.
// Honours THRESH_FG_COUNT_EN the same way as the design build.
`timescale 1ns/1ps
module tb_ram_threshold_master;
   localparam int WORDS    = 1024;
   localparam int LAST_WR  = 3 * WORDS;
   localparam int DONE_CYC = LAST_WR + 1;
`ifdef THRESH_FG_COUNT_EN
   localparam bit FG_EN = 1'b1;
`else
   localparam bit FG_EN = 1'b0;
`endif

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [15:0] thr   = '0;
   logic        mod_en, wr_en, rd_en, busy, done;
   logic [9:0]  addr_in;
   logic [15:0] data_in;
   logic [15:0] data_o;
   logic [10:0] fg_count;

   ram_threshold_master #(.DATA_W(16), .ADDR_W(10)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .thr      (thr),
      .mod_en   (mod_en),
      .wr_en    (wr_en),
      .rd_en    (rd_en),
      .addr_in  (addr_in),
      .data_in  (data_in),
      .data_o   (data_o),
      .busy     (busy),
      .done     (done),
      .fg_count (fg_count)
   );

   always #5 clk = ~clk;

   // Synchronous RAM with a bench-side bulk fill and single-word poke.
   logic [15:0] mem [WORDS];
   logic        fill_req  = 1'b0;
   logic        fill_zero = 1'b0;
   logic        poke_req  = 1'b0;
   logic [9:0]  poke_addr = '0;
   logic [15:0] poke_data = '0;

   always @(posedge clk) begin
      if (fill_req) begin
         for (int a = 0; a < WORDS; a++) mem[a] <= fill_zero ? 16'h0000 : 16'(a);
      end else if (poke_req) begin
         mem[poke_addr] <= poke_data;
      end else if (mod_en && wr_en) begin
         mem[addr_in] <= data_in;
      end
      if (mod_en && rd_en) data_o <= mem[addr_in];
   end

   int          checks   = 0;
   int          failures = 0;
   bit          in_frame = 1'b0;
   int          cyc      = 0;
   int          run_fg   = 0;
   int          done_cyc = -1;
   int          pix;
   int          phase;
   logic [15:0] pre [WORDS];
   logic [15:0] thr_m = '0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] thresh(input logic [15:0] v, input logic [15:0] t);
      return (v >= t) ? 16'hFFFF : 16'h0000;
   endfunction

   // Cycle n after an accepted start: pixel (n-1)/3 in phase read/wait/write, then done at 3*WORDS+1.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_mod_en", mod_en, 0);
         chk("rst_wr_en", wr_en, 0);
         chk("rst_rd_en", rd_en, 0);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_addr", addr_in, 0);
         chk("rst_data_in", data_in, 0);
         chk("rst_fg", fg_count, 0);
      end else if (in_frame) begin
         cyc++;
         chk("rd_wr_excl", rd_en & wr_en, 0);
         chk("fg_running", fg_count, FG_EN ? run_fg : 0);
         if (done && done_cyc < 0) done_cyc = cyc;
         if (cyc <= LAST_WR) begin
            pix   = (cyc - 1) / 3;
            phase = (cyc - 1) % 3;
            chk("busy_frame", busy, 1);
            chk("done_frame", done, 0);
            if (phase == 0) begin
               chk("read_mod_en", mod_en, 1);
               chk("read_rd_en", rd_en, 1);
               chk("read_wr_en", wr_en, 0);
               chk("read_addr", addr_in, pix);
            end else if (phase == 1) begin
               chk("wait_mod_en", mod_en, 0);
               chk("wait_rd_en", rd_en, 0);
               chk("wait_wr_en", wr_en, 0);
            end else begin
               chk("write_mod_en", mod_en, 1);
               chk("write_wr_en", wr_en, 1);
               chk("write_rd_en", rd_en, 0);
               chk("write_addr", addr_in, pix);
               chk("write_data", data_in, thresh(pre[pix], thr_m));
               if (pre[pix] >= thr_m) run_fg++;
            end
         end else begin
            chk("done_pulse", done, 1);
            chk("done_busy", busy, 0);
            chk("done_mod_en", mod_en, 0);
            chk("done_rd_en", rd_en, 0);
            chk("done_wr_en", wr_en, 0);
            in_frame = 1'b0;
         end
      end else begin
         chk("idle_busy", busy, 0);
         chk("idle_done", done, 0);
         chk("idle_mod_en", mod_en, 0);
         chk("idle_rd_en", rd_en, 0);
         chk("idle_wr_en", wr_en, 0);
         chk("idle_fg", fg_count, FG_EN ? run_fg : 0);
      end
   end

   task automatic do_fill(input bit zero);
      @(negedge clk); #1;
      fill_zero = zero;
      fill_req  = 1'b1;
      @(posedge clk); #1;
      fill_req  = 1'b0;
   endtask

   task automatic do_poke(input logic [9:0] a, input logic [15:0] d);
      @(negedge clk); #1;
      poke_addr = a;
      poke_data = d;
      poke_req  = 1'b1;
      @(posedge clk); #1;
      poke_req  = 1'b0;
   endtask

   task automatic do_start(input logic [15:0] t);
      @(negedge clk); #1;
      for (int a = 0; a < WORDS; a++) pre[a] = mem[a];
      thr_m    = t;
      thr      = t;
      start    = 1'b1;
      cyc      = 0;
      run_fg   = 0;
      done_cyc = -1;
      in_frame = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
   endtask

   task automatic wait_frame();
      int n = 0;
      while (in_frame && n < DONE_CYC + 100) begin
         @(negedge clk); #1;
         n++;
      end
      chk("frame_timeout", in_frame, 0);
      repeat (2) @(negedge clk);
      #1;
   endtask

   task automatic check_mem(input string name, input int thr_upto);
      for (int a = 0; a < WORDS; a++) begin
         if (a < thr_upto) chk(name, mem[a], thresh(pre[a], thr_m));
         else              chk(name, mem[a], pre[a]);
      end
   endtask

   initial begin
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_addr", addr_in, 0);
      chk("reset_busy", busy, 0);
      @(negedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Identity ramp, thr=512: half background, half foreground.
      do_fill(1'b0);
      do_start(16'd512);
      wait_frame();
      check_mem("ramp512_mem", WORDS);
      chk("ramp512_done_cycle", done_cyc, 3073);
      chk("ramp512_fg", fg_count, FG_EN ? 512 : 0);
      chk("ramp512_w511", mem[511], 16'h0000);
      chk("ramp512_w512", mem[512], 16'hFFFF);

      // thr=0: every pixel foreground, fg_count needs its 11th bit.
      do_fill(1'b0);
      do_start(16'd0);
      wait_frame();
      check_mem("ramp0_mem", WORDS);
      chk("ramp0_fg", fg_count, FG_EN ? 1024 : 0);
      chk("ramp0_w0", mem[0], 16'hFFFF);

      // All zero, thr=max: nothing foreground; then a single 0xFFFF word.
      do_fill(1'b1);
      do_start(16'hFFFF);
      wait_frame();
      check_mem("zeros_mem", WORDS);
      chk("zeros_fg", fg_count, 0);
      do_poke(10'd7, 16'hFFFF);
      do_start(16'hFFFF);
      wait_frame();
      check_mem("word7_mem", WORDS);
      chk("word7_fg", fg_count, FG_EN ? 1 : 0);
      chk("word7_w7", mem[7], 16'hFFFF);
      chk("word7_w6", mem[6], 16'h0000);

      // Starts during the frame and on the done cycle must be ignored; thr changes must not leak in.
      do_fill(1'b0);
      do_start(16'd512);
      begin
         int n = 0;
         while (cyc < 50 && n < 200) begin @(negedge clk); #1; n++; end
         chk("mid_start_reached", cyc, 50);
      end
      thr   = 16'd0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      begin
         int n = 0;
         while (in_frame && n < DONE_CYC + 100) begin @(negedge clk); #1; n++; end
         chk("done_start_reached", cyc, DONE_CYC);
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      check_mem("ignore_mem", WORDS);
      chk("ignore_fg", fg_count, FG_EN ? 512 : 0);
      chk("ignore_done_cycle", done_cyc, 3073);

      // Reset while pixel 100 is being read: frame abandoned, restart from address 0.
      do_fill(1'b0);
      do_start(16'd512);
      begin
         int n = 0;
         while (cyc < 301 && n < 400) begin @(negedge clk); #1; n++; end
      end
      chk("abort_addr_before", addr_in, 100);
      chk("abort_rd_before", rd_en, 1);
      rst_n    = 1'b0;
      in_frame = 1'b0;
      run_fg   = 0;
      #1;
      chk("abort_async_mod_en", mod_en, 0);
      chk("abort_async_rd_en", rd_en, 0);
      chk("abort_async_busy", busy, 0);
      chk("abort_async_addr", addr_in, 0);
      chk("abort_async_fg", fg_count, 0);
      repeat (3) @(negedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check_mem("abort_mem", 100);
      do_start(16'd512);
      chk("restart_addr", addr_in, 0);
      chk("restart_rd_en", rd_en, 1);
      wait_frame();
      check_mem("restart_mem", WORDS);
      chk("restart_fg", fg_count, FG_EN ? 512 : 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
